// File: rtl/ecc_scrubber_if.sv
// Cache data-array port shared by the ECC scrubber and the array owner.
// Read data and check bits return in the cycle after arr_re.
interface ecc_scrubber_if;
  logic        arr_req;
  logic        arr_gnt;
  logic [8:0]  arr_addr;
  logic        arr_re;
  logic [31:0] arr_dout;
  logic [6:0]  arr_pout;
  logic        arr_dwe;
  logic        arr_pwe;
  logic [31:0] arr_din;
  logic [6:0]  arr_pin;

  modport master (
    output arr_req,
    output arr_addr,
    output arr_re,
    output arr_dwe,
    output arr_pwe,
    output arr_din,
    output arr_pin,
    input  arr_gnt,
    input  arr_dout,
    input  arr_pout
  );

  modport slave (
    input  arr_req,
    input  arr_addr,
    input  arr_re,
    input  arr_dwe,
    input  arr_pwe,
    input  arr_din,
    input  arr_pin,
    output arr_gnt,
    output arr_dout,
    output arr_pout
  );
endinterface

// File: rtl/ecc_scrubber.sv
// Background SECDED(39,32) scrubber for the cache data array.
// Define ECC_SCRUB_WB_EN to write corrected words back to the array.
module ecc_scrubber #(
  parameter int DEPTH    = 512,
  parameter int INTERVAL = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_scrub_en,
  ecc_scrubber_if.master arr,
  output logic           o_busy,
  output logic [15:0]    o_sec_count,
  output logic           o_ded_err,
  output logic [8:0]     o_ded_addr,
  output logic           o_ded_pulse
);

  localparam int CW = $clog2(INTERVAL) + 1;

`ifdef ECC_SCRUB_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_RD,
    S_CHK,
    S_WB,
    S_NEXT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [8:0]    r_addr;
  logic [CW-1:0] r_wcnt;
  logic [15:0]   r_sec;
  logic          r_ded_err;
  logic [8:0]    r_ded_addr;

  logic [5:0]    w_syn;
  logic          w_o;
  logic          w_single;
  logic          w_double;
  logic          w_sec_inc;
  logic          w_ded;
  logic          w_last;

  function automatic logic f_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bits occupy the non-power-of-two Hamming positions in order.
  function automatic logic [5:0] f_hcheck(input logic [31:0] d);
    logic [5:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!f_pow2(p)) begin
        if (d[k[4:0]]) c = c ^ 6'(p);
        k++;
      end
    end
    return c;
  endfunction

  always_comb begin
    w_syn    = f_hcheck(arr.arr_dout) ^ arr.arr_pout[5:0];
    w_o      = ^{arr.arr_dout, arr.arr_pout};
    w_single = w_o && (w_syn <= 6'd38);
    w_double = (!w_o && (w_syn != 6'd0))
            || (w_o && (w_syn > 6'd38));
  end

  assign w_last    = (r_addr == 9'(DEPTH - 1));
  assign w_ded     = (r_state == S_CHK) && arr.arr_gnt
                  && w_double;
  assign w_sec_inc = WB_EN
                   ? ((r_state == S_WB) && arr.arr_gnt)
                   : ((r_state == S_CHK) && arr.arr_gnt
                      && w_single);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_scrub_en) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_scrub_en)
          w_next = S_IDLE;
        else if (r_wcnt == CW'(INTERVAL - 1))
          w_next = S_REQ;
      end
      S_REQ: begin
        if (arr.arr_gnt) w_next = S_RD;
      end
      S_RD: begin
        w_next = arr.arr_gnt ? S_CHK : S_REQ;
      end
      S_CHK: begin
        if (!arr.arr_gnt)
          w_next = S_REQ;
        else if (WB_EN && w_single)
          w_next = S_WB;
        else
          w_next = S_NEXT;
      end
      S_WB: begin
        w_next = arr.arr_gnt ? S_NEXT : S_REQ;
      end
      S_NEXT: begin
        if (!i_scrub_en)
          w_next = S_IDLE;
        else if (w_last)
          w_next = S_WAIT;
        else
          w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_WAIT) && (w_next == S_WAIT))
        r_wcnt <= r_wcnt + 1'b1;
      else
        r_wcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (r_state == S_NEXT) begin
      r_addr <= w_last ? 9'd0 : r_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sec      <= '0;
      r_ded_err  <= 1'b0;
      r_ded_addr <= '0;
    end else begin
      if (w_sec_inc && (r_sec != 16'hFFFF))
        r_sec <= r_sec + 1'b1;
      if (w_ded) begin
        r_ded_err <= 1'b1;
        if (!r_ded_err) r_ded_addr <= r_addr;
      end
    end
  end

`ifdef ECC_SCRUB_WB_EN
  logic        w_pflip;
  logic        w_dflip;
  logic [31:0] w_cdata;
  logic [6:0]  w_cpar;
  logic [31:0] w_dmask;
  logic [31:0] r_din;
  logic [6:0]  r_pin;
  logic        r_dflip;
  logic        r_pflip;

  always_comb begin
    w_dmask = '0;
    for (int p = 1, k = 0; p <= 38; p++) begin
      if (!f_pow2(p)) begin
        if (6'(p) == w_syn) w_dmask[k[4:0]] = 1'b1;
        k++;
      end
    end
  end

  // A zero syndrome with parity mismatch means pin[6] itself flipped.
  always_comb begin
    w_pflip = w_single
           && ((w_syn == 6'd0) || f_pow2(int'(w_syn)));
    w_dflip = w_single && !w_pflip;
    w_cdata = arr.arr_dout;
    w_cpar  = arr.arr_pout;
    if (w_pflip)
      w_cpar = arr.arr_pout ^ {(w_syn == 6'd0), w_syn};
    if (w_dflip)
      w_cdata = arr.arr_dout ^ w_dmask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_din   <= '0;
      r_pin   <= '0;
      r_dflip <= 1'b0;
      r_pflip <= 1'b0;
    end else if (r_state == S_CHK) begin
      r_din   <= w_cdata;
      r_pin   <= w_cpar;
      r_dflip <= w_dflip;
      r_pflip <= w_pflip;
    end
  end

  assign arr.arr_dwe = (r_state == S_WB) && arr.arr_gnt
                    && r_dflip;
  assign arr.arr_pwe = (r_state == S_WB) && arr.arr_gnt
                    && r_pflip;
  assign arr.arr_din = r_din;
  assign arr.arr_pin = r_pin;
`else
  assign arr.arr_dwe = 1'b0;
  assign arr.arr_pwe = 1'b0;
  assign arr.arr_din = '0;
  assign arr.arr_pin = '0;
`endif

  assign arr.arr_req = (r_state == S_REQ) || (r_state == S_RD)
                    || (r_state == S_CHK) || (r_state == S_WB);
  assign arr.arr_re   = (r_state == S_RD) && arr.arr_gnt;
  assign arr.arr_addr = r_addr;

  assign o_busy      = (r_state != S_IDLE) && (r_state != S_WAIT);
  assign o_sec_count = r_sec;
  assign o_ded_err   = r_ded_err;
  assign o_ded_addr  = r_ded_addr;
  assign o_ded_pulse = w_ded;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Bench for ecc_scrubber: random array contents with injected bit flips,
// judged by Hamming distance from the clean codeword.
module tb_ecc_scrubber;
  localparam int DEPTH    = 512;
  localparam int INTERVAL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        scrub_en;
  logic        gnt;
  logic        busy;
  logic [15:0] sec_count;
  logic        ded_err;
  logic [8:0]  ded_addr;
  logic        ded_pulse;

  ecc_scrubber_if bus();

  ecc_scrubber #(
    .DEPTH   (DEPTH),
    .INTERVAL(INTERVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_scrub_en (scrub_en),
    .arr        (bus),
    .o_busy     (busy),
    .o_sec_count(sec_count),
    .o_ded_err  (ded_err),
    .o_ded_addr (ded_addr),
    .o_ded_pulse(ded_pulse)
  );

  always #5 clk = ~clk;

  assign bus.arr_gnt = gnt;

  logic [31:0] mem_d [DEPTH];
  logic [6:0]  mem_p [DEPTH];
  logic [38:0] clean [DEPTH];

  always @(posedge clk) begin
    if (bus.arr_re === 1'b1) begin
      bus.arr_dout <= mem_d[bus.arr_addr];
      bus.arr_pout <= mem_p[bus.arr_addr];
    end
  end

  int n_rd;
  int n_dwe;
  int n_pwe;
  int n_ded;
  int rd_cnt [DEPTH];
  int wr_cnt [DEPTH];
`ifdef ECC_SCRUB_WB_EN
  logic [1:0]  wr_flags [DEPTH];
  logic [38:0] wr_word  [DEPTH];
`endif

  always @(negedge clk) begin
    if (bus.arr_re === 1'b1) begin
      n_rd <= n_rd + 1;
      rd_cnt[bus.arr_addr] <= rd_cnt[bus.arr_addr] + 1;
    end
    if (bus.arr_dwe === 1'b1) n_dwe <= n_dwe + 1;
    if (bus.arr_pwe === 1'b1) n_pwe <= n_pwe + 1;
    if ((bus.arr_dwe === 1'b1) || (bus.arr_pwe === 1'b1)) begin
      wr_cnt[bus.arr_addr] <= wr_cnt[bus.arr_addr] + 1;
`ifdef ECC_SCRUB_WB_EN
      wr_flags[bus.arr_addr] <= {bus.arr_dwe, bus.arr_pwe};
      wr_word[bus.arr_addr]  <= {bus.arr_pin, bus.arr_din};
`endif
    end
    if (ded_pulse === 1'b1) n_ded <= n_ded + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference SECDED encoder built from the codeword layout itself.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic cw [1:38];
    logic [6:0] p;
    int k;
    k = 0;
    for (int i = 1; i <= 38; i++) begin
      if ((i & (i - 1)) == 0) begin
        cw[i] = 1'b0;
      end else begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      p[j] = 1'b0;
      for (int i = 1; i <= 38; i++)
        if (((i >> j) & 1) == 1) p[j] = p[j] ^ cw[i];
    end
    p[6] = ^{d, p[5:0]};
    return {p, d};
  endfunction

  task automatic put(input int a, input logic [38:0] w);
    mem_d[a] = w[31:0];
    mem_p[a] = w[38:32];
  endtask

  task automatic flip(input int a, input int b);
    logic [38:0] w;
    w = {mem_p[a], mem_d[a]};
    w[b] = ~w[b];
    put(a, w);
  endtask

  task automatic wait_busy(input logic v, input int budget,
                           output int n, output bit ok);
    n = 0;
    ok = 1'b1;
    while (busy !== v) begin
      if (n >= budget) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_re(input bit any, input int a, input int budget,
                         output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((bus.arr_re === 1'b1)
          && (any || (bus.arr_addr === 9'(a)))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_req"}, bus.arr_req, 1'b0);
    chk({tag, "_re"}, bus.arr_re, 1'b0);
    chk({tag, "_dwe"}, bus.arr_dwe, 1'b0);
    chk({tag, "_pwe"}, bus.arr_pwe, 1'b0);
    chk({tag, "_sec"}, sec_count, 16'd0);
    chk({tag, "_ded_err"}, ded_err, 1'b0);
    chk({tag, "_ded_addr"}, ded_addr, 9'd0);
    chk({tag, "_ded_pulse"}, ded_pulse, 1'b0);
  endtask

  int n;
  bit ok;
  int nsgl, ndbl, ndat, npar, fdbl, cnt;
  int s_rd, s_dwe, s_pwe, s_ded, s_rd5, s_wr5;
  int rs_a [3];
  int rs_b [3];
  int b0, b1;
  logic [38:0] x;

  initial begin
    rst = 1'b0;
    scrub_en = 1'b0;
    gnt = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      clean[a] = enc($urandom);
      put(a, clean[a]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");
    rst = 1'b1;

    // Two clean sweeps: timing, interval and no side effects.
    s_rd = n_rd;
    scrub_en = 1'b1;
    wait_busy(1'b1, 100, n, ok);
    chk("start_ok", ok, 1'b1);
    chk("start_lat", n, INTERVAL + 1);
    wait_busy(1'b0, 3000, n, ok);
    chk("sweep1_ok", ok, 1'b1);
    chk("sweep_len", n, 4 * DEPTH);
    wait_busy(1'b1, 100, n, ok);
    chk("gap_len", n, INTERVAL);
    wait_busy(1'b0, 3000, n, ok);
    chk("sweep2_ok", ok, 1'b1);
    scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("clean_reads", n_rd - s_rd, 2 * DEPTH);
    chk("clean_sec", sec_count, 16'd0);
    chk("clean_ded", ded_err, 1'b0);
    chk("clean_dwe", n_dwe, 0);
    chk("clean_pwe", n_pwe, 0);
    chk("clean_pulse", n_ded, 0);

    // Directed and random bit flips.
    flip(1, 1);
    flip(8, 34);
    flip(9, 0);
    flip(9, 38);
    b0 = $urandom_range(0, 38);
    b1 = (b0 + 1 + $urandom_range(0, 37)) % 39;
    flip(20, b0);
    flip(20, b1);
    rs_a[0] = $urandom_range(30, 160);
    rs_a[1] = $urandom_range(170, 330);
    rs_a[2] = $urandom_range(340, 499);
    for (int i = 0; i < 3; i++) begin
      rs_b[i] = $urandom_range(0, 38);
      flip(rs_a[i], rs_b[i]);
    end
    nsgl = 0; ndbl = 0; ndat = 0; npar = 0; fdbl = -1;
    for (int a = 0; a < DEPTH; a++) begin
      x = {mem_p[a], mem_d[a]} ^ clean[a];
      if ($countones(x) == 1) begin
        nsgl++;
        if (x[31:0] != 32'd0) ndat++;
        else npar++;
      end else if ($countones(x) == 2) begin
        ndbl++;
        if (fdbl < 0) fdbl = a;
      end
    end
    s_dwe = n_dwe;
    s_pwe = n_pwe;
    s_ded = n_ded;
    scrub_en = 1'b1;
    wait_busy(1'b1, 100, n, ok);
    wait_busy(1'b0, 4000, n, ok);
    chk("err_sweep_ok", ok, 1'b1);
    scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_sec", sec_count, nsgl);
    chk("err_ded_err", ded_err, 1'b1);
    chk("err_ded_addr", ded_addr, fdbl);
    chk("err_pulses", n_ded - s_ded, ndbl);
    chk("no_wr_9", wr_cnt[9], 0);
    chk("no_wr_20", wr_cnt[20], 0);
`ifdef ECC_SCRUB_WB_EN
    chk("wb_dwe_cnt", n_dwe - s_dwe, ndat);
    chk("wb_pwe_cnt", n_pwe - s_pwe, npar);
    chk("wb1_flags", wr_flags[1], 2'b10);
    chk("wb1_word", wr_word[1], clean[1]);
    chk("wb8_flags", wr_flags[8], 2'b01);
    chk("wb8_word", wr_word[8], clean[8]);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (wr_word[rs_a[i]] !== clean[rs_a[i]]) cnt++;
      if (wr_flags[rs_a[i]] !== ((rs_b[i] < 32) ? 2'b10 : 2'b01))
        cnt++;
    end
    chk("wb_rand_bad", cnt, 0);
`else
    chk("nowb_dwe_cnt", n_dwe - s_dwe, 0);
    chk("nowb_pwe_cnt", n_pwe - s_pwe, 0);
`endif

    // Grant withheld, then revoked in the check cycle of entry 5.
    for (int a = 0; a < DEPTH; a++) put(a, clean[a]);
    flip(5, $urandom_range(0, 31));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gnt = 1'b0;
    scrub_en = 1'b1;
    s_rd5 = rd_cnt[5];
    s_wr5 = wr_cnt[5];
    s_dwe = n_dwe;
    s_pwe = n_pwe;
    wait_busy(1'b1, 100, n, ok);
    chk("nogrant_req_ok", ok, 1'b1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.arr_req === 1'b1) cnt++;
    end
    chk("req_held", cnt, 10);
    gnt = 1'b1;
    wait_re(1'b0, 5, 100, ok);
    chk("rd5_ok", ok, 1'b1);
    @(posedge clk);
    #1 gnt = 1'b0;
    @(negedge clk);
    chk("req_in_abort", bus.arr_req, 1'b1);
    @(posedge clk);
    #1 gnt = 1'b1;
    wait_re(1'b0, 10, 200, ok);
    chk("rd10_ok", ok, 1'b1);
    chk("rd5_twice", rd_cnt[5] - s_rd5, 2);
    chk("abort_sec", sec_count, 16'd1);
    chk("abort_ded", ded_err, 1'b0);
    chk("wr5_cnt", wr_cnt[5] - s_wr5, WB_CNT());
    chk("abort_wr_tot", (n_dwe - s_dwe) + (n_pwe - s_pwe), WB_CNT());

    // Reset mid-entry at address 100.
    flip(100, $urandom_range(0, 31));
    wait_re(1'b0, 100, 600, ok);
    chk("rd100_ok", ok, 1'b1);
    @(posedge clk);
    #1;
`ifdef ECC_SCRUB_WB_EN
    @(posedge clk);
    #1;
    chk("wb100_dwe", bus.arr_dwe, 1'b1);
`endif
    chk("mid_addr", bus.arr_addr, 9'd100);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst1");
    rst = 1'b1;
    wait_re(1'b1, 0, 100, ok);
    chk("after_rst_ok", ok, 1'b1);
    chk("after_rst_addr", bus.arr_addr, 9'd0);

    // Disable mid-sweep, then resume from the retained address.
    wait_re(1'b0, 3, 100, ok);
    chk("rd3_ok", ok, 1'b1);
    scrub_en = 1'b0;
    wait_busy(1'b0, 20, n, ok);
    chk("stop_ok", ok, 1'b1);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if ((bus.arr_req === 1'b1) || (busy === 1'b1)) cnt++;
    end
    chk("idle_quiet", cnt, 0);
    scrub_en = 1'b1;
    wait_re(1'b1, 0, 100, ok);
    chk("resume_ok", ok, 1'b1);
    chk("resume_addr", bus.arr_addr, 9'd4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  function automatic int WB_CNT();
`ifdef ECC_SCRUB_WB_EN
    return 1;
`else
    return 0;
`endif
  endfunction

endmodule
